// File: rtl/ara_pkg.sv
// Lane-wide types shared by the mask path: vector-instruction IDs, mask beats
// and the indices of the FUs that consume mask beats.
package ara_pkg;

   localparam int unsigned NrVInsn   = 8;
   localparam int unsigned DataWidth = 64;

   typedef logic [$clog2(NrVInsn)-1:0] vid_t;
   typedef logic [DataWidth/8-1:0]     strb_t;

   typedef enum int unsigned {
      MaskFUAlu    = 0,
      MaskFUMFpu   = 1,
      NrMaskFUnits = 2
   } mask_fu_e;

endpackage

// File: rtl/mask_tag_fifo.sv
// Per-FU mask beat buffer: circular FIFO with synchronous flush; the head is
// read straight from the storage registers, so there is no fall-through path.
module mask_tag_fifo #(
   parameter int unsigned Depth = 2,
   parameter type         T     = logic [7:0]
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic flush_i,
   input  logic push_i,
   input  T     data_i,
   output logic full_o,
   input  logic pop_i,
   output logic valid_o,
   output T     data_o
);

   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   T                mem_q [Depth];
   T                mem_d [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            push, pop;

   function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (cnt_q == CntW'(Depth));
   assign valid_o = (cnt_q != '0);
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      push     = push_i && !full_o;
      pop      = pop_i && valid_o;
      // Flush wins over a same-cycle pop; the upstream already blocks pushes.
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wrap_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = wrap_inc(rd_ptr_q);
         end
         cnt_d = cnt_q + CntW'(push) - CntW'(pop);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/lane_mask_router.sv
// Steers each vid-tagged mask beat to the one FU running that masked vinsn,
// buffering per FU; TaggedMode=0 falls back to the plain lane broadcast.
module lane_mask_router
   import ara_pkg::*;
#(
   parameter int unsigned NrFUs      = NrMaskFUnits,
   parameter int unsigned FifoDepth  = 2,
   parameter bit          TaggedMode = 1'b1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  strb_t               mask_i,
   input  vid_t                mask_vid_i,
   input  logic                mask_valid_i,
   output logic                mask_ready_o,
   input  vid_t  [NrFUs-1:0]   fu_vid_i,
   input  logic  [NrFUs-1:0]   fu_vid_valid_i,
   input  logic  [NrFUs-1:0]   fu_flush_i,
   output strb_t [NrFUs-1:0]   fu_mask_o,
   output logic  [NrFUs-1:0]   fu_mask_valid_o,
   input  logic  [NrFUs-1:0]   fu_mask_ready_i,
   output logic                unmatched_o
);

   if (TaggedMode) begin : gen_tagged
      localparam int unsigned IdxW = (NrFUs > 1) ? $clog2(NrFUs) : 1;

      logic [NrFUs-1:0] hit;
      logic [NrFUs-1:0] full;
      logic [NrFUs-1:0] push;
      logic             match;
      logic [IdxW-1:0]  target;

      always_comb begin
         hit    = '0;
         match  = 1'b0;
         target = '0;
         for (int unsigned f = 0; f < NrFUs; f++) begin
            hit[f] = fu_vid_valid_i[f] && (fu_vid_i[f] == mask_vid_i);
            // Lowest index wins should two FUs ever claim the same vid.
            if (hit[f] && !match) begin
               match  = 1'b1;
               target = IdxW'(f);
            end
         end
      end

      // Ready looks only at local FIFO state, never at the FUs' ready inputs.
      assign mask_ready_o = mask_valid_i && match && !full[target] && !fu_flush_i[target];
      assign unmatched_o  = mask_valid_i && !match;

      for (genvar f = 0; f < NrFUs; f++) begin : gen_fifo
         assign push[f] = mask_ready_o && (target == IdxW'(f));

         mask_tag_fifo #(
            .Depth (FifoDepth),
            .T     (strb_t)
         ) i_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (fu_flush_i[f]),
            .push_i  (push[f]),
            .data_i  (mask_i),
            .full_o  (full[f]),
            .pop_i   (fu_mask_ready_i[f]),
            .valid_o (fu_mask_valid_o[f]),
            .data_o  (fu_mask_o[f])
         );
      end

      a_unique_vid_match: assert property (
         @(posedge clk_i) disable iff (!rst_ni) mask_valid_i |-> $onehot0(hit)
      );
   end else begin : gen_legacy
      logic unused_legacy;

      assign fu_mask_o       = {NrFUs{mask_i}};
      assign fu_mask_valid_o = {NrFUs{mask_valid_i}};
      assign mask_ready_o    = |fu_mask_ready_i;
      assign unmatched_o     = 1'b0;
      assign unused_legacy   = ^{clk_i, rst_ni, mask_vid_i, fu_vid_i, fu_vid_valid_i, fu_flush_i};
   end

endmodule

// File: tb/tb_lane_mask_router.sv
// Bench for lane_mask_router: per-FU queue reference model for the tagged
// instance plus a direct rule check of a legacy-mode instance.
module tb_lane_mask_router;
   import ara_pkg::*;

   localparam int unsigned NF    = 2;
   localparam int unsigned Depth = 2;

   typedef logic [19:0] vec_t;
   typedef struct packed {
      strb_t      m;
      vid_t       vid;
      logic       v;
      logic       fl1;
      logic [1:0] rdy;
      logic       er;
   } fl_step_t;

   logic clk = 1'b0;
   logic rst_n;

   strb_t           mask;
   vid_t            mask_vid;
   logic            mask_valid;
   vid_t  [NF-1:0]  fu_vid;
   logic  [NF-1:0]  fu_vid_valid, fu_flush, fu_rdy;
   logic            ready, unmatched;
   strb_t [NF-1:0]  fu_mask;
   logic  [NF-1:0]  fu_valid;

   strb_t           l_mask;
   logic            l_valid, l_ready, l_unm;
   logic  [NF-1:0]  l_rdy, l_fu_valid;
   strb_t [NF-1:0]  l_fu_mask;

   strb_t mq [NF][$];
   int    n_vec = 0;
   int    n_err = 0;

   always #5 clk = ~clk;

   lane_mask_router #(.NrFUs(NF), .FifoDepth(Depth), .TaggedMode(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .mask_i(mask), .mask_vid_i(mask_vid),
      .mask_valid_i(mask_valid), .mask_ready_o(ready), .fu_vid_i(fu_vid),
      .fu_vid_valid_i(fu_vid_valid), .fu_flush_i(fu_flush), .fu_mask_o(fu_mask),
      .fu_mask_valid_o(fu_valid), .fu_mask_ready_i(fu_rdy), .unmatched_o(unmatched)
   );

   lane_mask_router #(.NrFUs(NF), .FifoDepth(Depth), .TaggedMode(1'b0)) dut_leg (
      .clk_i(clk), .rst_ni(rst_n), .mask_i(l_mask), .mask_vid_i(mask_vid),
      .mask_valid_i(l_valid), .mask_ready_o(l_ready), .fu_vid_i(fu_vid),
      .fu_vid_valid_i(fu_vid_valid), .fu_flush_i(fu_flush), .fu_mask_o(l_fu_mask),
      .fu_mask_valid_o(l_fu_valid), .fu_mask_ready_i(l_rdy), .unmatched_o(l_unm)
   );

   // Reference model: target is the lowest FU holding the beat's vid.
   function automatic bit exp_target(output int t);
      t = 0;
      for (int f = 0; f < NF; f++) begin
         if (fu_vid_valid[f] && fu_vid[f] == mask_vid) begin
            t = f;
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic bit exp_ready();
      int t;
      if (!mask_valid) return 1'b0;
      if (!exp_target(t)) return 1'b0;
      return (mq[t].size() < Depth) && !fu_flush[t];
   endfunction

   function automatic vec_t expv();
      int    t;
      bit    m;
      strb_t h0, h1;
      m  = exp_target(t);
      h0 = (mq[0].size() != 0) ? mq[0][0] : strb_t'(0);
      h1 = (mq[1].size() != 0) ? mq[1][0] : strb_t'(0);
      return {exp_ready(), mask_valid && !m, mq[1].size() != 0, mq[0].size() != 0, h1, h0};
   endfunction

   function automatic vec_t obsv();
      return {ready, unmatched, fu_valid,
              fu_valid[1] ? fu_mask[1] : strb_t'(0),
              fu_valid[0] ? fu_mask[0] : strb_t'(0)};
   endfunction

   // Advance the model across one clock edge, then move to just after it.
   task automatic tick();
      int t;
      bit acc;
      acc = exp_ready();
      void'(exp_target(t));
      for (int f = 0; f < NF; f++) begin
         if (fu_flush[f]) mq[f].delete();
         else if (mq[f].size() != 0 && fu_rdy[f]) void'(mq[f].pop_front());
      end
      if (acc) mq[t].push_back(mask);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      n_vec++;
      if ({ready, unmatched, fu_valid, fu_mask} !== 20'h0) begin
         n_err++;
         $display("FAIL reset_state: got %h want 00000", {ready, unmatched, fu_valid, fu_mask});
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      n_vec++;
      if (obsv() !== expv()) begin
         n_err++;
         $display("FAIL reset_release: got %h want %h", obsv(), expv());
      end
      tick();
   endtask

   task automatic test_tagged_routing();
      fu_vid[0] = 3'd3; fu_vid[1] = 3'd5; fu_vid_valid = 2'b11; fu_rdy = 2'b00; fu_flush = 2'b00;
      mask = 8'hAA; mask_vid = 3'd5; mask_valid = 1'b1;
      #1;
      n_vec++;
      if (obsv() !== expv() || ready !== 1'b1) begin
         n_err++;
         $display("FAIL routing_c0: got %h want %h", obsv(), expv());
      end
      tick();
      mask = 8'h55; mask_vid = 3'd3;
      #1;
      n_vec++;
      if (obsv() !== expv() || fu_valid !== 2'b10 || fu_mask[1] !== 8'hAA) begin
         n_err++;
         $display("FAIL routing_c1: got %h want %h", obsv(), expv());
      end
      tick();
      mask_valid = 1'b0; fu_rdy = 2'b11;
      #1;
      n_vec++;
      if (obsv() !== expv() || fu_valid !== 2'b11 || fu_mask[0] !== 8'h55 || fu_mask[1] !== 8'hAA) begin
         n_err++;
         $display("FAIL routing_c2: got %h want %h", obsv(), expv());
      end
      tick();
      #1;
      n_vec++;
      if (obsv() !== expv() || fu_valid !== 2'b00) begin
         n_err++;
         $display("FAIL routing_drained: got %h want %h", obsv(), expv());
      end
      tick();
   endtask

   task automatic test_backpressure();
      strb_t beats [3] = '{8'h11, 8'h22, 8'h33};
      bit    want [10] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0};
      int    idx = 0;
      bit    acc;
      fu_vid[0] = 3'd3; fu_vid[1] = 3'd5; fu_vid_valid = 2'b11; fu_flush = 2'b00;
      mask_vid = 3'd3;
      for (int c = 0; c < 10; c++) begin
         fu_rdy     = {1'b0, c >= 4};
         mask_valid = (idx < 3);
         mask       = (idx < 3) ? beats[idx] : strb_t'(0);
         #1;
         n_vec++;
         if (obsv() !== expv() || ready !== want[c]) begin
            n_err++;
            $display("FAIL backpressure c%0d: got %h want %h (ready want %0d)", c, obsv(), expv(), want[c]);
         end
         acc = exp_ready();
         tick();
         if (acc) idx++;
      end
   endtask

   task automatic test_unmatched();
      fu_vid[0] = 3'd3; fu_vid[1] = 3'd5; fu_vid_valid = 2'b11; fu_rdy = 2'b00; fu_flush = 2'b00;
      mask = 8'h77; mask_vid = 3'd7; mask_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_vec++;
         if (obsv() !== expv() || ready !== 1'b0 || unmatched !== 1'b1) begin
            n_err++;
            $display("FAIL unmatched c%0d: got %h want %h", c, obsv(), expv());
         end
         tick();
      end
      fu_vid[1] = 3'd7;
      #1;
      n_vec++;
      if (obsv() !== expv() || ready !== 1'b1 || unmatched !== 1'b0) begin
         n_err++;
         $display("FAIL unmatched_claim: got %h want %h", obsv(), expv());
      end
      tick();
      mask_valid = 1'b0; fu_rdy = 2'b10;
      #1;
      n_vec++;
      if (obsv() !== expv() || fu_valid !== 2'b10 || fu_mask[1] !== 8'h77) begin
         n_err++;
         $display("FAIL unmatched_deliver: got %h want %h", obsv(), expv());
      end
      tick();
   endtask

   task automatic test_flush();
      fl_step_t s [8] = '{
         '{8'hC0, 3'd3, 1'b1, 1'b0, 2'b00, 1'b1},
         '{8'hD1, 3'd5, 1'b1, 1'b0, 2'b00, 1'b1},
         '{8'hD2, 3'd5, 1'b1, 1'b0, 2'b00, 1'b1},
         '{8'hD3, 3'd5, 1'b1, 1'b1, 2'b00, 1'b0},
         '{8'hD3, 3'd5, 1'b1, 1'b1, 2'b00, 1'b0},
         '{8'hD3, 3'd5, 1'b1, 1'b0, 2'b00, 1'b1},
         '{8'h00, 3'd0, 1'b0, 1'b0, 2'b11, 1'b0},
         '{8'h00, 3'd0, 1'b0, 1'b0, 2'b11, 1'b0}
      };
      fu_vid[0] = 3'd3; fu_vid[1] = 3'd5; fu_vid_valid = 2'b11;
      for (int c = 0; c < 8; c++) begin
         mask = s[c].m; mask_vid = s[c].vid; mask_valid = s[c].v;
         fu_flush = {s[c].fl1, 1'b0}; fu_rdy = s[c].rdy;
         #1;
         n_vec++;
         if (obsv() !== expv() || ready !== s[c].er
             || (c == 4 && (fu_valid !== 2'b01 || fu_mask[0] !== 8'hC0))
             || (c == 6 && (fu_valid !== 2'b11 || fu_mask[0] !== 8'hC0 || fu_mask[1] !== 8'hD3))) begin
            n_err++;
            $display("FAIL flush c%0d: got %h want %h", c, obsv(), expv());
         end
         tick();
      end
   endtask

   task automatic test_concurrency();
      int acc_n = 0;
      fu_vid[0] = 3'd3; fu_vid[1] = 3'd5; fu_vid_valid = 2'b11; fu_rdy = 2'b11; fu_flush = 2'b00;
      for (int i = 0; i < 102; i++) begin
         mask_valid = (i < 100);
         mask       = strb_t'($urandom);
         mask_vid   = (i % 2 == 1) ? 3'd5 : 3'd3;
         #1;
         n_vec++;
         if (obsv() !== expv() || ready !== (i < 100)) begin
            n_err++;
            $display("FAIL concurrency i%0d: got %h want %h", i, obsv(), expv());
         end
         if (ready === 1'b1) acc_n++;
         tick();
      end
      n_vec++;
      if (acc_n !== 100) begin
         n_err++;
         $display("FAIL concurrency_count: got %0d want 100", acc_n);
      end
   endtask

   task automatic test_random();
      bit acc;
      mask_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            fu_vid[0]    = vid_t'($urandom_range(0, 7));
            fu_vid[1]    = fu_vid[0] + vid_t'($urandom_range(1, 7));
            fu_vid_valid = 2'($urandom);
         end
         fu_rdy   = 2'($urandom);
         fu_flush = {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0};
         if (!mask_valid) begin
            mask_valid = ($urandom_range(0, 3) != 0);
            mask       = strb_t'($urandom);
            case ($urandom_range(0, 3))
               0:       mask_vid = fu_vid[0];
               1, 2:    mask_vid = fu_vid[1];
               default: mask_vid = vid_t'($urandom);
            endcase
         end
         #1;
         n_vec++;
         if (obsv() !== expv()) begin
            n_err++;
            $display("FAIL random i%0d: got %h want %h", i, obsv(), expv());
         end
         acc = exp_ready();
         tick();
         if (acc) mask_valid = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      strb_t b [3] = '{8'h01, 8'h02, 8'h03};
      vid_t  v [3] = '{3'd3, 3'd3, 3'd5};
      fu_vid[0] = 3'd3; fu_vid[1] = 3'd5; fu_vid_valid = 2'b11; fu_rdy = 2'b00;
      mask_valid = 1'b0; fu_flush = 2'b11;
      #1;
      tick();
      fu_flush = 2'b00;
      for (int c = 0; c < 3; c++) begin
         mask = b[c]; mask_vid = v[c]; mask_valid = 1'b1;
         #1;
         n_vec++;
         if (obsv() !== expv() || ready !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_fill c%0d: got %h want %h", c, obsv(), expv());
         end
         tick();
      end
      mask = 8'h04; mask_vid = 3'd5;
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (fu_valid !== 2'b00 || fu_mask !== 16'h0) begin
         n_err++;
         $display("FAIL rstmid_async: got valid %b mask %h want 00 0000", fu_valid, fu_mask);
      end
      for (int f = 0; f < NF; f++) mq[f].delete();
      @(posedge clk);
      #1;
      mask_valid = 1'b0; fu_rdy = 2'b11;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_vec++;
         if (obsv() !== expv() || fu_valid !== 2'b00) begin
            n_err++;
            $display("FAIL rstmid_after c%0d: got %h want %h", c, obsv(), expv());
         end
         tick();
      end
   endtask

   task automatic test_legacy();
      for (int i = 0; i < 24; i++) begin
         l_mask   = strb_t'($urandom);
         l_valid  = (i == 0) ? 1'b1 : 1'($urandom);
         l_rdy    = (i == 0) ? 2'b10 : 2'($urandom);
         mask_vid = vid_t'($urandom);
         #1;
         n_vec++;
         if ({l_ready, l_unm, l_fu_valid, l_fu_mask} !== {|l_rdy, 1'b0, {2{l_valid}}, {2{l_mask}}}) begin
            n_err++;
            $display("FAIL legacy i%0d: got %b %b %b %h want rdy=%b valid=%b mask=%h",
                     i, l_ready, l_unm, l_fu_valid, l_fu_mask, |l_rdy, l_valid, l_mask);
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      mask = '0; mask_vid = '0; mask_valid = 1'b0;
      fu_vid = '0; fu_vid_valid = '0; fu_flush = '0; fu_rdy = '0;
      l_mask = '0; l_valid = 1'b0; l_rdy = '0;
      test_reset();
      test_tagged_routing();
      test_backpressure();
      test_unmatched();
      test_flush();
      test_concurrency();
      test_random();
      test_reset_mid();
      test_legacy();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1);
   end

endmodule
